// File: rtl/ghost_speed_scheduler.sv
// rtl/ghost_speed_scheduler.sv - ghost difficulty level and speed_offset scheduler
// Optional feature macro: SPEED_RAMP_EN (per-frame ramp of speed_offset toward target).
module ghost_speed_scheduler #(
  parameter int LEVEL_POINTS = 16,
  parameter int MAX_LEVEL    = 15,
  parameter int MAX_OFFSET   = 2750000,
  parameter int RAMP_STEP    = 4096
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        game_en,
  input  logic        frame_tick,
  input  logic        new_score,
  input  logic [13:0] score,
  output logic [25:0] speed_offset,
  output logic [3:0]  level,
  output logic        level_up,
  output logic        busy
);

  localparam logic [13:0] LP   = 14'(LEVEL_POINTS);
  localparam logic [3:0]  MAXL = 4'(MAX_LEVEL);
  localparam logic [25:0] MAXO = 26'(MAX_OFFSET);

  typedef enum logic [1:0] {IDLE, COMPUTE, COMMIT} state_t;

  state_t      state, state_next;
  logic [13:0] rem;
  logic [13:0] pending_score;
  logic [3:0]  cnt;
  logic        pending;
  logic [25:0] target;
  logic        load;
  logic [13:0] load_score;
  logic [25:0] scaled;
  logic [25:0] load_target;
  logic        can_sub;

  // Select which score enters the computation and derive its capped target
  always_comb begin
    load        = (state == IDLE && new_score) || (state == COMMIT && (pending || new_score));
    load_score  = (state == COMMIT && !new_score) ? pending_score : score;
    scaled      = {2'b00, load_score[13:2], 12'b0};
    load_target = (scaled > MAXO) ? MAXO : scaled;
    can_sub     = (rem >= LP) && (cnt < MAXL);
  end

  // State register
  always_ff @(posedge clk) begin
    if (reset) state <= IDLE;
    else       state <= state_next;
  end

  // Next-state logic
  always_comb begin
    state_next = state;
    case (state)
      IDLE:    if (new_score) state_next = COMPUTE;
      COMPUTE: if (!can_sub)  state_next = COMMIT;
      COMMIT:  state_next = load ? COMPUTE : IDLE;
      default: state_next = IDLE;
    endcase
  end

  // Output decode: busy covers the subtraction phase only
  always_comb begin
    busy = (state == COMPUTE);
  end

  // Iterative level computation, pending score capture and commit
  always_ff @(posedge clk) begin
    if (reset) begin
      rem           <= '0;
      cnt           <= '0;
      target        <= '0;
      pending       <= 1'b0;
      pending_score <= '0;
      level         <= '0;
      level_up      <= 1'b0;
    end else begin
      level_up <= 1'b0;
      if (load) begin
        rem    <= load_score;
        cnt    <= '0;
        target <= load_target;
      end else if (state == COMPUTE && can_sub) begin
        rem <= rem - LP;
        cnt <= cnt + 4'd1;
      end
      if (state == COMMIT) begin
        level    <= cnt;
        level_up <= (cnt > level);
      end
      // A score arriving mid-computation waits; the newest one wins
      if (new_score && state == COMPUTE) begin
        pending       <= 1'b1;
        pending_score <= score;
      end else if (load) begin
        pending <= 1'b0;
      end
    end
  end

`ifdef SPEED_RAMP_EN
  localparam logic [25:0] STEP = 26'(RAMP_STEP);

  // Ramp toward the target once per frame; drops snap immediately
  always_ff @(posedge clk) begin
    if (reset) begin
      speed_offset <= '0;
    end else if (frame_tick && game_en) begin
      if (speed_offset < target && (target - speed_offset) > STEP)
        speed_offset <= speed_offset + STEP;
      else
        speed_offset <= target;
    end
  end
`else
  logic ramp_inputs_unused;
  assign ramp_inputs_unused = frame_tick & game_en & (RAMP_STEP != 0);

  // Legacy instant speed: follow the target one clock after it is latched
  always_ff @(posedge clk) begin
    if (reset) speed_offset <= '0;
    else       speed_offset <= target;
  end
`endif

endmodule

// File: doc/ghost_speed_scheduler.md
Name: ghost_speed_scheduler

Overview:
- Difficulty controller for the ghost enemy units; it replaces the ad-hoc combinational speed_offset assignment in the top level.
- Latches the egg score on each new_score pulse and computes a difficulty level by iterative subtraction.
- Drives a shared speed_offset to ghost_crazy, ghost_top and ghost_bottom, ramping it toward a capped target once per video frame while the game is enabled.

Parameters:
- LEVEL_POINTS, 16: score points per difficulty level.
- MAX_LEVEL, 15: saturation value of level.
- MAX_OFFSET, 2750000: ceiling for speed_offset and target.
- RAMP_STEP, 4096: maximum increase of speed_offset per frame_tick.

Ports:
- clk  in  1  system clock
- reset  in  1  synchronous, active-high; top level drives hard_reset | game_reset
- game_en  in  1  high in playing state; ramping is frozen when low
- frame_tick  in  1  one-clk pulse per frame (x==0 && y==0 && pixel_tick)
- new_score  in  1  one-clk pulse; score is valid in the same cycle
- score  in  14  binary egg score
- speed_offset  out  26  registered offset routed to all ghosts
- level  out  4  current difficulty level
- level_up  out  1  one-clk pulse when level increases
- busy  out  1  high while the level computation is in progress

Behaviour:
- Reset (sync, active-high, clk edge): speed_offset=0, level=0, level_up=0, busy=0, target=0, pending=0, state=IDLE. Reset wins over every other input in the same cycle, including mid-COMPUTE.
- Target arithmetic: target = min({12'b0, score[13:2]} << 12, MAX_OFFSET), computed at 26 bits. No overflow is possible: the maximum is 4095<<12 = 16773120 < 2^26.
- FSM states: IDLE, COMPUTE, COMMIT.
  - IDLE: on new_score, latch score into rem, set cnt=0 and target, go to COMPUTE. busy goes high the next cycle.
  - COMPUTE: one subtraction per clk. If rem >= LEVEL_POINTS and cnt < MAX_LEVEL, then rem -= LEVEL_POINTS and cnt++. Otherwise go to COMMIT.
  - COMMIT (1 clk): level <= cnt. Pulse level_up if cnt > old level. busy <= 0. Go to IDLE, or straight back to COMPUTE with the pending score if pending=1.
  - Worst-case latency from new_score to level update is MAX_LEVEL+2 clks.
- new_score while busy: latch the score into a pending register and set pending=1. A later pulse overwrites the pending score (last value wins). pending clears when that score is loaded. Target is updated only when a score is loaded into the computation, never from pending directly.
- Ramp (only if SPEED_RAMP_EN is defined), evaluated on frame_tick && game_en:
  - speed_offset < target: speed_offset <= min(speed_offset + RAMP_STEP, target).
  - speed_offset > target: snap down to target on the same tick.
  - speed_offset == target: hold.
- game_en low: speed_offset holds its value. The level computation still runs.
- frame_tick and new_score in the same cycle: the ramp uses the old target and the new target applies from the next tick.
- speed_offset must never exceed MAX_OFFSET or target.
- level saturates at MAX_LEVEL. level_up never pulses at saturation or after reset.

Optional Feature:
- Macro: SPEED_RAMP_EN.
- Defined: per-frame ramping exactly as described in Behaviour.
- Undefined: speed_offset <= target one clk after the target is latched, regardless of frame_tick and game_en. This matches the legacy instant-speed behaviour.

Test Plan:
- Reset, then score=100 pulse → busy high for 7 clks; level=6; level_up pulses once; target=102400. With the ramp enabled, speed_offset reaches 102400 after exactly 25 frame_ticks (4096 per tick), then holds.
- score=16383 → level=15 (saturated) after 17 clks; target=2750000. With the ramp enabled, speed_offset is 2748416 after tick 671 and 2750000 after tick 672, never more.
- score=40 then, 3 clks later, score=80 while busy → first commit level=2, pending compute follows, final level=5. Two level_up pulses total.
- Ramp at 8192, game_en=0 with 10 frame_ticks → speed_offset stays 8192. After game_en=1, the next tick gives 12288.
- Reset asserted mid-COMPUTE with speed_offset=40960 → next clk all outputs are 0 and state is IDLE. A following new_score with score=0 gives level=0 and no level_up.
- SPEED_RAMP_EN undefined, score=100 → speed_offset=102400 with no frame_tick applied.
